// File: rtl/rf_transceiver_pkg.sv
// rtl/rf_transceiver_pkg.sv - shared mode, TX FSM and framing constants for the RF transceiver
package rf_transceiver_pkg;

    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_HEADER   = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    localparam logic [7:0] WAKEUP_BYTE = 8'hAA;
    localparam int         HDR_LEN     = 3;

    // Only modes 0 and 1 carry host data over the air.
    function automatic logic is_tx_mode(input logic [1:0] mode);
        return (mode == MODE_0) || (mode == MODE_1);
    endfunction

endpackage

// File: rtl/rf_tx_timer.sv
// rtl/rf_tx_timer.sv - loadable saturating down-counter shared by idle timeout and inter-packet gap
module rf_tx_timer #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    assign o_zero = (r_count == '0);

    // Load has priority; decrement stops at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/rf_tx_packet_scheduler.sv
// rtl/rf_tx_packet_scheduler.sv - packetises UART-RX FIFO bytes onto the RF TX serializer; RF_TX_ADDR_HEADER_EN adds address/channel header
module rf_tx_packet_scheduler
    import rf_transceiver_pkg::*;
#(
    parameter int PACKET_SIZE  = 58,
    parameter int IDLE_TIMEOUT = 3000,
    parameter int WAKEUP_LEN   = 4,
    parameter int GAP_CYCLES   = 200,
    parameter int CNT_W        = 8
) (
    input  logic             internal_clk,
    input  logic             rst,
    input  logic             M0_sync,
    input  logic             M1_sync,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd,
    output logic [7:0]       rf_data,
    output logic             rf_valid,
    input  logic             rf_ready,
    input  logic [7:0]       addr_h,
    input  logic [7:0]       addr_l,
    input  logic [7:0]       channel,
    output logic             AUX_tx_ctrl,
    output logic             tx_busy,
    output logic             packet_done
);

    localparam int TMR_MAX = (IDLE_TIMEOUT > GAP_CYCLES) ? IDLE_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] PKT_THRESH = CNT_W'(PACKET_SIZE);
`ifdef RF_TX_ADDR_HEADER_EN
    localparam logic [2:0] ST_AFTER_PRE = ST_HEADER;
`else
    localparam logic [2:0] ST_AFTER_PRE = ST_SEND;
`endif

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_len;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_prev_count;
    logic             r_aux;
    logic             r_busy;
    logic             r_done;

    logic             w_tx_mode;
    logic             w_count_stable;
    logic             w_trigger;
    logic             w_accept;
    logic [CNT_W-1:0] w_len_latch;
    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic [7:0]       w_hdr_byte;

    assign w_tx_mode      = is_tx_mode({M1_sync, M0_sync});
    assign w_count_stable = (fifo_count == r_prev_count);
    assign w_len_latch    = (fifo_count >= PKT_THRESH) ? PKT_THRESH : fifo_count;
    // The down-counter reaching zero while the count is unchanged means the
    // up-counting idle time has hit IDLE_TIMEOUT.
    assign w_trigger = (r_state == ST_IDLE) && w_tx_mode &&
                       ((fifo_count >= PKT_THRESH) ||
                        ((fifo_count != '0) && w_count_stable && w_tmr_zero));
    assign w_accept    = rf_valid & rf_ready;
    assign fifo_rd     = (r_state == ST_SEND) & w_accept;
    assign AUX_tx_ctrl = r_aux;
    assign tx_busy     = r_busy;
    assign packet_done = r_done;

`ifdef RF_TX_ADDR_HEADER_EN
    logic [7:0] r_addr_h;
    logic [7:0] r_addr_l;
    logic [7:0] r_channel;

    // Header fields are frozen at trigger so the packet is self-consistent.
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            r_addr_h  <= '0;
            r_addr_l  <= '0;
            r_channel <= '0;
        end else if (w_trigger) begin
            r_addr_h  <= addr_h;
            r_addr_l  <= addr_l;
            r_channel <= channel;
        end
    end

    // Header byte selected by position within the header.
    always_comb begin
        w_hdr_byte = r_channel;
        if (r_idx == 4'd0) w_hdr_byte = r_addr_h;
        else if (r_idx == 4'd1) w_hdr_byte = r_addr_l;
    end
`else
    logic w_unused_hdr;
    assign w_unused_hdr = ^{addr_h, addr_l, channel};
    assign w_hdr_byte   = 8'h00;
`endif

    // Serializer-facing byte and valid, purely from state so reset clears them at once.
    always_comb begin
        rf_valid = 1'b0;
        rf_data  = 8'h00;
        case (r_state)
            ST_PREAMBLE: begin
                rf_valid = 1'b1;
                rf_data  = WAKEUP_BYTE;
            end
            ST_HEADER: begin
                rf_valid = 1'b1;
                rf_data  = w_hdr_byte;
            end
            ST_SEND: begin
                rf_valid = ~fifo_empty;
                rf_data  = fifo_dout;
            end
            default: ;
        endcase
    end

    // Timer runs as idle timeout in IDLE and as guard counter in GAP.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        w_tmr_val  = TMR_W'(IDLE_TIMEOUT);
        case (r_state)
            ST_IDLE: begin
                if (!w_tx_mode || (fifo_count == '0) || !w_count_stable) w_tmr_load = 1'b1;
                else w_tmr_dec = 1'b1;
            end
            ST_SEND: begin
                if (w_accept && (r_len == CNT_W'(1))) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) w_tmr_load = 1'b1;
                else w_tmr_dec = 1'b1;
            end
            default: ;
        endcase
    end

    rf_tx_timer #(.W(TMR_W)) u_timer (
        .i_clk      (internal_clk),
        .i_rst      (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Packet FSM; the mode is captured by the state chosen at trigger.
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_prev_count <= '0;
            r_aux        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_prev_count <= fifo_count;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_len   <= w_len_latch;
                        r_idx   <= '0;
                        r_aux   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= M0_sync ? ST_PREAMBLE : ST_AFTER_PRE;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_accept) begin
                        if (r_idx == 4'(WAKEUP_LEN - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_AFTER_PRE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        if (r_idx == 4'(HDR_LEN - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_SEND;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_len == CNT_W'(1)) r_state <= ST_GAP;
                        r_len <= r_len - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_IDLE;
                        r_aux   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_tx_packet_scheduler.sv
// tb/tb_rf_tx_packet_scheduler.sv - directed self-checking bench for rf_tx_packet_scheduler
module tb_rf_tx_packet_scheduler;

    localparam int PACKET_SIZE  = 58;
    localparam int IDLE_TIMEOUT = 3000;
    localparam int WAKEUP_LEN   = 4;
    localparam int GAP_CYCLES   = 200;
    localparam int CNT_W        = 8;
`ifdef RF_TX_ADDR_HEADER_EN
    localparam int HDR = 3;
`else
    localparam int HDR = 0;
`endif

    logic             internal_clk = 1'b0;
    logic             rst = 1'b1;
    logic             M0_sync = 1'b0;
    logic             M1_sync = 1'b0;
    logic             rf_ready = 1'b0;
    logic [7:0]       addr_h = 8'h12;
    logic [7:0]       addr_l = 8'h34;
    logic [7:0]       channel = 8'h17;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_dout;
    logic             fifo_rd;
    logic [7:0]       rf_data;
    logic             rf_valid;
    logic             AUX_tx_ctrl;
    logic             tx_busy;
    logic             packet_done;

    rf_tx_packet_scheduler #(
        .PACKET_SIZE(PACKET_SIZE), .IDLE_TIMEOUT(IDLE_TIMEOUT), .WAKEUP_LEN(WAKEUP_LEN),
        .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .internal_clk(internal_clk), .rst(rst), .M0_sync(M0_sync), .M1_sync(M1_sync),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .rf_data(rf_data), .rf_valid(rf_valid), .rf_ready(rf_ready),
        .addr_h(addr_h), .addr_l(addr_l), .channel(channel),
        .AUX_tx_ctrl(AUX_tx_ctrl), .tx_busy(tx_busy), .packet_done(packet_done)
    );

    always #5 internal_clk = ~internal_clk;

    // FWFT FIFO model feeding the scheduler; it keeps its contents across DUT reset.
    logic [7:0] mem [0:1023];
    int         wr = 0;
    int         rd = 0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    int         seq = 1;

    assign fifo_count = CNT_W'(wr - rd);
    assign fifo_empty = (wr == rd);
    assign fifo_dout  = mem[rd % 1024];

    always @(posedge internal_clk) begin
        if (push) begin
            mem[wr % 1024] <= push_data;
            wr <= wr + 1;
        end
        if (fifo_rd) rd <= rd + 1;
    end

    int cyc = 0;
    always @(posedge internal_clk) cyc <= cyc + 1;

    // Monitor on the falling edge; cyc there equals the index of the preceding rising edge.
    logic [7:0] cap[$];
    int         done_caps[$];
    int         done_cnt = 0;
    int         rd_cnt = 0;
    int         last_acc = 0;
    int         aux_rise = 0;
    int         busy_rise = 0;
    int         valid_rise = 0;
    int         hold_viol = 0;
    logic       prev_aux = 1'b1;
    logic       prev_busy = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge internal_clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_valid <= 1'b0;
            prev_busy  <= 1'b0;
            prev_aux   <= 1'b1;
        end else begin
            if (rf_valid && rf_ready) begin
                cap.push_back(rf_data);
                last_acc <= cyc + 1;
            end
            if (prev_stall && (!rf_valid || rf_data !== prev_data)) hold_viol <= hold_viol + 1;
            prev_stall <= rf_valid && !rf_ready;
            prev_data  <= rf_data;
            if (packet_done) begin
                done_cnt <= done_cnt + 1;
                done_caps.push_back(cap.size());
            end
            if (fifo_rd) rd_cnt <= rd_cnt + 1;
            if (AUX_tx_ctrl && !prev_aux) aux_rise <= cyc;
            if (tx_busy && !prev_busy) busy_rise <= cyc;
            if (rf_valid && !prev_valid) valid_rise <= cyc;
            prev_aux   <= AUX_tx_ctrl;
            prev_busy  <= tx_busy;
            prev_valid <= rf_valid;
        end
    end

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] expq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            push_data = 8'(seq);
            seq++;
            @(posedge internal_clk);
            #1;
        end
        push = 1'b0;
    endtask

    // Expected air bytes of one packet: optional preamble, optional header, FIFO payload.
    task automatic expect_pkt(input bit m1, input int start, input int n);
        if (m1) for (int j = 0; j < WAKEUP_LEN; j++) expq.push_back(8'hAA);
`ifdef RF_TX_ADDR_HEADER_EN
        expq.push_back(addr_h);
        expq.push_back(addr_l);
        expq.push_back(channel);
`endif
        for (int j = 0; j < n; j++) expq.push_back(mem[(start + j) % 1024]);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, cap.size(), expq.size());
        for (int j = 0; j < expq.size() && j < cap.size(); j++)
            check($sformatf("%s_b%0d", tag, j), cap[j], expq[j]);
        cap.delete();
        expq.delete();
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge internal_clk);
            #1;
            k++;
        end
        check({tag, "_done_in_time"}, done_cnt >= target, 1);
    endtask

    initial begin
        int start;
        int pe;
        int k;

        repeat (3) @(posedge internal_clk);
        #1;
        check("rst_rf_valid", rf_valid, 0);
        check("rst_rf_data", rf_data, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_aux", AUX_tx_ctrl, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_packet_done", packet_done, 0);
        rst = 1'b0;
        rf_ready = 1'b1;

        // Full-size packet in mode 0.
        start = wr;
        push_bytes(PACKET_SIZE);
        expect_pkt(0, start, PACKET_SIZE);
        wait_done(1, 1000, "t1");
        check_stream("t1");
        check("t1_first_valid_with_busy", valid_rise, busy_rise);
        check("t1_gap_cycles", aux_rise - last_acc, GAP_CYCLES);
        check("t1_done_once", done_cnt, 1);
        check("t1_fifo_drained", fifo_count, 0);
        check("t1_aux_idle", AUX_tx_ctrl, 1);

        // Partial packet by idle timeout: one edge to clear the timer after the
        // last count change, IDLE_TIMEOUT increments, then the trigger edge.
        start = wr;
        push_bytes(5);
        pe = cyc;
        expect_pkt(0, start, 5);
        wait_done(2, 3500, "t2");
        check("t2_trigger_delay", busy_rise - pe, IDLE_TIMEOUT + 2);
        check_stream("t2");
        check("t2_fifo_drained", fifo_count, 0);

        // Mode 1: wake-up preamble ahead of payload.
        M0_sync = 1'b1;
        start = wr;
        push_bytes(10);
        expect_pkt(1, start, 10);
        wait_done(3, 3500, "t3");
        check_stream("t3");
        check("t3_first_valid_with_busy", valid_rise, busy_rise);
        M0_sync = 1'b0;

        // Mode 3 holds the FIFO; mode 0 then sends a full packet and the remainder.
        M0_sync = 1'b1;
        M1_sync = 1'b1;
        pe = rd_cnt;
        start = wr;
        push_bytes(70);
        repeat (IDLE_TIMEOUT + 100) @(posedge internal_clk);
        #1;
        check("t4_no_pop_mode3", rd_cnt - pe, 0);
        check("t4_aux_mode3", AUX_tx_ctrl, 1);
        check("t4_busy_mode3", tx_busy, 0);
        check("t4_count_mode3", fifo_count, 70);
        M0_sync = 1'b0;
        M1_sync = 1'b0;
        expect_pkt(0, start, PACKET_SIZE);
        expect_pkt(0, start + PACKET_SIZE, 70 - PACKET_SIZE);
        wait_done(5, 4500, "t4");
        check("t4_first_pkt_len", done_caps[3], PACKET_SIZE + HDR);
        check("t4_second_pkt_len", done_caps[4], 70 + 2 * HDR);
        check_stream("t4");

        // Back-pressure toggling plus a mode flip to 2 mid-packet.
        rf_ready = 1'b0;
        start = wr;
        push_bytes(PACKET_SIZE);
        expect_pkt(0, start, PACKET_SIZE);
        k = 0;
        while (done_cnt < 6 && k < 1000) begin
            @(posedge internal_clk);
            #1;
            rf_ready = ~rf_ready;
            if (k == 20) M1_sync = 1'b1;
            k++;
        end
        check("t5_done_in_time", done_cnt >= 6, 1);
        check("t5_hold_violations", hold_viol, 0);
        check_stream("t5");
        M1_sync = 1'b0;
        rf_ready = 1'b1;

        // Reset mid-SEND: outputs fall to reset values immediately.
        start = wr;
        push_bytes(PACKET_SIZE);
        k = 0;
        while (cap.size() < 10 + HDR && k < 300) begin
            @(posedge internal_clk);
            #1;
            k++;
        end
        check("t6_reached_send", cap.size() >= 10 + HDR, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_rf_valid", rf_valid, 0);
        check("t6_rst_rf_data", rf_data, 0);
        check("t6_rst_fifo_rd", fifo_rd, 0);
        check("t6_rst_aux", AUX_tx_ctrl, 1);
        check("t6_rst_busy", tx_busy, 0);
        @(posedge internal_clk);
        #1;
        rst = 1'b0;
        cap.delete();
        expq.delete();
        check("t6_bytes_left", (wr - rd) > 0 && (wr - rd) < PACKET_SIZE, 1);
        expect_pkt(0, rd, wr - rd);
        wait_done(7, 3600, "t6");
        check_stream("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
